// File: rtl/ticket_vending_fsm.sv
// Ticket-vending controller: prices a journey selection, collects money,
// hands tickets to the printer one at a time and returns change or a refund.
module ticket_vending_fsm #(
  parameter int NUM_STATIONS = 8,
  parameter int STN_W        = 3,
  parameter int TKT_W        = 3,
  parameter int MAX_TICKETS  = 7,
  parameter int MONEY_W      = 8,
  parameter int ACC_W        = 12,
  parameter int BASE_FARE    = 10,
  parameter int HOP_FARE     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sel_valid,
  input  logic [STN_W-1:0]   ini_state,
  input  logic [STN_W-1:0]   des_state,
  input  logic [TKT_W-1:0]   ticketnum,
  input  logic               money_valid,
  input  logic [MONEY_W-1:0] inputmoney,
  input  logic               cancel,
  input  logic               ticket_ready,
  output logic               ticket_valid,
  output logic [TKT_W-1:0]   ticket_left,
  output logic [ACC_W-1:0]   total_due,
  output logic [ACC_W-1:0]   paid,
  output logic               change_valid,
  output logic [ACC_W-1:0]   change_amount,
  output logic               refund,
  output logic               sel_err,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PAY      = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4
  } state_e;

  localparam int SUM_W = ACC_W + 1;
  localparam logic [TKT_W-1:0] ONE_TKT = TKT_W'(1);

  state_e             state_q, state_d;
  logic [TKT_W-1:0]   ticket_left_q, ticket_left_d;
  logic [ACC_W-1:0]   total_due_q, total_due_d;
  logic [ACC_W-1:0]   paid_q, paid_d;
  logic [ACC_W-1:0]   change_amount_q, change_amount_d;
  logic               ticket_valid_q, ticket_valid_d;
  logic               change_valid_q, change_valid_d;
  logic               refund_q, refund_d;
  logic               sel_err_q, sel_err_d;

  logic [STN_W-1:0]   dist_s;
  logic [31:0]        fare_s;
  logic [31:0]        total_wide_s;
  logic               sel_bad_s;
  logic [SUM_W-1:0]   sum_s;
  logic [ACC_W-1:0]   paid_sat_s;

  // Price the presented selection and decide whether it is acceptable
  always_comb begin
    dist_s       = (ini_state > des_state) ? (ini_state - des_state) : (des_state - ini_state);
    fare_s       = 32'(BASE_FARE) + (32'(HOP_FARE) * 32'(dist_s));
    total_wide_s = fare_s * 32'(ticketnum);
    sel_bad_s    = (ini_state == des_state)
                || (int'(ini_state) >= NUM_STATIONS)
                || (int'(des_state) >= NUM_STATIONS)
                || (ticketnum == {TKT_W{1'b0}})
                || (int'(ticketnum) > MAX_TICKETS)
                || ((total_wide_s >> ACC_W) != 32'd0);
  end

  // Saturating accumulation of the inserted money
  always_comb begin
    sum_s      = {1'b0, paid_q} + SUM_W'(inputmoney);
    paid_sat_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
  end

  // Next-state and next-output logic; strobes are computed one cycle ahead
  always_comb begin
    state_d         = state_q;
    ticket_left_d   = ticket_left_q;
    total_due_d     = total_due_q;
    paid_d          = paid_q;
    change_amount_d = {ACC_W{1'b0}};
    change_valid_d  = 1'b0;
    refund_d        = 1'b0;
    sel_err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          if (sel_bad_s) begin
            sel_err_d = 1'b1;
          end else begin
            total_due_d   = total_wide_s[ACC_W-1:0];
            ticket_left_d = ticketnum;
            paid_d        = {ACC_W{1'b0}};
            state_d       = PAY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PAY: begin
        if (money_valid) begin
          paid_d = paid_sat_s;
        end else begin
          paid_d = paid_q;
        end
        // Cancel wins even when this cycle's money would have met the price
        if (cancel) begin
          state_d         = REFUND;
          change_valid_d  = 1'b1;
          refund_d        = 1'b1;
          change_amount_d = paid_d;
        end else if (paid_d >= total_due_q) begin
          state_d = DISPENSE;
        end else begin
          state_d = PAY;
        end
      end
      DISPENSE: begin
        if (ticket_valid_q && ticket_ready) begin
          ticket_left_d = ticket_left_q - ONE_TKT;
          if (ticket_left_q == ONE_TKT) begin
            state_d         = CHANGE;
            change_valid_d  = 1'b1;
            change_amount_d = paid_q - total_due_q;
          end else begin
            state_d = DISPENSE;
          end
        end else begin
          state_d = DISPENSE;
        end
      end
      CHANGE:  state_d = IDLE;
      REFUND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ticket_valid_d = (state_d == DISPENSE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      ticket_left_q   <= {TKT_W{1'b0}};
      total_due_q     <= {ACC_W{1'b0}};
      paid_q          <= {ACC_W{1'b0}};
      change_amount_q <= {ACC_W{1'b0}};
      ticket_valid_q  <= 1'b0;
      change_valid_q  <= 1'b0;
      refund_q        <= 1'b0;
      sel_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      ticket_left_q   <= ticket_left_d;
      total_due_q     <= total_due_d;
      paid_q          <= paid_d;
      change_amount_q <= change_amount_d;
      ticket_valid_q  <= ticket_valid_d;
      change_valid_q  <= change_valid_d;
      refund_q        <= refund_d;
      sel_err_q       <= sel_err_d;
    end
  end

  assign ticket_valid  = ticket_valid_q;
  assign ticket_left   = ticket_left_q;
  assign total_due     = total_due_q;
  assign paid          = paid_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign refund        = refund_q;
  assign sel_err       = sel_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_ticket_vending_fsm.sv
// Directed bench for ticket_vending_fsm; change/refund strobes are checked
// against a scoreboard filled when the triggering stimulus is driven.
module tb_ticket_vending_fsm;

  localparam int STN_W = 4;
  localparam int TKT_W = 3;
  localparam int ACC_W = 12;

  typedef struct packed {
    logic             refund;
    logic [ACC_W-1:0] amount;
  } ret_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             sel_valid;
  logic [STN_W-1:0] ini_state;
  logic [STN_W-1:0] des_state;
  logic [TKT_W-1:0] ticketnum;
  logic             money_valid;
  logic [7:0]       inputmoney;
  logic             cancel;
  logic             ticket_ready;
  logic             ticket_valid;
  logic [TKT_W-1:0] ticket_left;
  logic [ACC_W-1:0] total_due;
  logic [ACC_W-1:0] paid;
  logic             change_valid;
  logic [ACC_W-1:0] change_amount;
  logic             refund;
  logic             sel_err;
  logic [2:0]       state_o;

  int   checks = 0;
  int   errors = 0;
  int   handshakes = 0;
  int   hs_before = 0;
  ret_t sb[$];

  ticket_vending_fsm #(.NUM_STATIONS(8), .STN_W(STN_W)) dut (
    .clk(clk), .reset(reset), .sel_valid(sel_valid), .ini_state(ini_state),
    .des_state(des_state), .ticketnum(ticketnum), .money_valid(money_valid),
    .inputmoney(inputmoney), .cancel(cancel), .ticket_ready(ticket_ready),
    .ticket_valid(ticket_valid), .ticket_left(ticket_left), .total_due(total_due),
    .paid(paid), .change_valid(change_valid), .change_amount(change_amount),
    .refund(refund), .sel_err(sel_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic int fare(input int ini, input int des);
    return 10 + 5 * ((ini > des) ? (ini - des) : (des - ini));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: note a handshake offered before the edge, then check any return strobe
  task automatic step();
    ret_t exp;
    logic hs;
    hs = ticket_valid && ticket_ready;
    @(posedge clk);
    #1;
    if (hs) handshakes++;
    if (change_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_change: observed amount %0d refund %0d expected no strobe",
               change_amount, refund);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("change_amount", 32'(change_amount), 32'(exp.amount));
        chk("refund_flag", 32'(refund), 32'(exp.refund));
      end
    end
  endtask

  task automatic select(input int ini, input int des, input int tn);
    sel_valid = 1'b1;
    ini_state = STN_W'(ini);
    des_state = STN_W'(des);
    ticketnum = TKT_W'(tn);
    step();
    sel_valid = 1'b0;
  endtask

  task automatic insert(input int amt);
    money_valid = 1'b1;
    inputmoney  = 8'(amt);
    step();
    money_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_paid"}, 32'(paid), 32'd0);
    chk({tag, "_total"}, 32'(total_due), 32'd0);
    chk({tag, "_left"}, 32'(ticket_left), 32'd0);
    chk({tag, "_tvalid"}, 32'(ticket_valid), 32'd0);
    chk({tag, "_cvalid"}, 32'(change_valid), 32'd0);
    chk({tag, "_camount"}, 32'(change_amount), 32'd0);
    chk({tag, "_refund"}, 32'(refund), 32'd0);
    chk({tag, "_selerr"}, 32'(sel_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; sel_valid = 1'b0; ini_state = '0; des_state = '0; ticketnum = '0;
    money_valid = 1'b0; inputmoney = 8'd0; cancel = 1'b0; ticket_ready = 1'b0;
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Normal purchase: 1 -> 4, three tickets, fare 25
    select(1, 4, 3);
    chk("n_state", 32'(state_o), 32'd1);
    chk("n_total", 32'(total_due), 32'(fare(1, 4) * 3));
    chk("n_left", 32'(ticket_left), 32'd3);
    chk("n_paid0", 32'(paid), 32'd0);
    insert(10); chk("n_paid10", 32'(paid), 32'd10);
    insert(50); chk("n_paid60", 32'(paid), 32'd60);
    chk("n_still_pay", 32'(state_o), 32'd1);
    sb.push_back('{refund: 1'b0, amount: ACC_W'(80 - fare(1, 4) * 3)});
    insert(20);
    chk("n_paid80", 32'(paid), 32'd80);
    chk("n_dispense", 32'(state_o), 32'd2);
    chk("n_tvalid", 32'(ticket_valid), 32'd1);
    hs_before = handshakes;
    ticket_ready = 1'b1;
    step(); chk("n_left2", 32'(ticket_left), 32'd2);
    step(); chk("n_left1", 32'(ticket_left), 32'd1);
    step();
    chk("n_left0", 32'(ticket_left), 32'd0);
    chk("n_change_state", 32'(state_o), 32'd3);
    chk("n_cvalid", 32'(change_valid), 32'd1);
    chk("n_handshakes", 32'(handshakes - hs_before), 32'd3);
    ticket_ready = 1'b0;
    step();
    chk("n_idle", 32'(state_o), 32'd0);
    chk("n_cvalid_drop", 32'(change_valid), 32'd0);

    // Cancel refund: 3 -> 1, five tickets, total 100, paid 71
    hs_before = handshakes;
    select(3, 1, 5);
    chk("c_total", 32'(total_due), 32'(fare(3, 1) * 5));
    insert(50); insert(10); insert(10); insert(1);
    chk("c_paid", 32'(paid), 32'd71);
    sb.push_back('{refund: 1'b1, amount: ACC_W'(71)});
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("c_refund_state", 32'(state_o), 32'd4);
    chk("c_cvalid", 32'(change_valid), 32'd1);
    chk("c_tvalid", 32'(ticket_valid), 32'd0);
    step();
    chk("c_idle", 32'(state_o), 32'd0);
    chk("c_no_tickets", 32'(handshakes - hs_before), 32'd0);

    // Printer backpressure: 0 -> 7, two tickets, total 90, pay 100
    select(0, 7, 2);
    chk("b_total", 32'(total_due), 32'(fare(0, 7) * 2));
    sb.push_back('{refund: 1'b0, amount: ACC_W'(100 - fare(0, 7) * 2)});
    insert(100);
    chk("b_dispense", 32'(state_o), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_stall_tvalid", 32'(ticket_valid), 32'd1);
      chk("b_stall_left", 32'(ticket_left), 32'd2);
    end
    ticket_ready = 1'b1; step(); chk("b_left1", 32'(ticket_left), 32'd1);
    ticket_ready = 1'b0; step(); chk("b_hold_left", 32'(ticket_left), 32'd1);
    chk("b_hold_tvalid", 32'(ticket_valid), 32'd1);
    ticket_ready = 1'b1; step(); chk("b_left0", 32'(ticket_left), 32'd0);
    chk("b_change_state", 32'(state_o), 32'd3);
    ticket_ready = 1'b0;
    step();
    chk("b_idle", 32'(state_o), 32'd0);

    // Rejected selections leave IDLE and the latched price untouched
    select(2, 2, 1);
    chk("r_same_err", 32'(sel_err), 32'd1);
    chk("r_same_state", 32'(state_o), 32'd0);
    chk("r_same_total", 32'(total_due), 32'd90);
    step(); chk("r_err_one_cycle", 32'(sel_err), 32'd0);
    select(1, 2, 0);
    chk("r_zero_err", 32'(sel_err), 32'd1);
    chk("r_zero_state", 32'(state_o), 32'd0);
    select(0, 8, 1);
    chk("r_range_err", 32'(sel_err), 32'd1);
    chk("r_range_state", 32'(state_o), 32'd0);
    chk("r_range_total", 32'(total_due), 32'd90);
    step();

    // Money and cancel in the same cycle: 20 held plus 50 refunded
    select(0, 2, 2);
    insert(20);
    chk("s_paid20", 32'(paid), 32'd20);
    sb.push_back('{refund: 1'b1, amount: ACC_W'(70)});
    cancel = 1'b1;
    insert(50);
    cancel = 1'b0;
    chk("s_refund_state", 32'(state_o), 32'd4);
    chk("s_paid70", 32'(paid), 32'd70);
    step();

    // Exact payment: 5 -> 6, two tickets, total 30, change 0
    select(5, 6, 2);
    sb.push_back('{refund: 1'b0, amount: ACC_W'(0)});
    insert(30);
    chk("e_dispense", 32'(state_o), 32'd2);
    ticket_ready = 1'b1;
    step(); step();
    chk("e_change_state", 32'(state_o), 32'd3);
    ticket_ready = 1'b0;
    step();

    // Asynchronous reset in DISPENSE with two tickets left
    select(0, 1, 3);
    insert(45);
    ticket_ready = 1'b1; step(); ticket_ready = 1'b0;
    chk("m_left2", 32'(ticket_left), 32'd2);
    #3 reset = 1'b1;
    #1 chk_all_zero("m_async");
    step();
    reset = 1'b0;
    ticket_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("m_post_state", 32'(state_o), 32'd0);
      chk("m_post_cvalid", 32'(change_valid), 32'd0);
    end
    ticket_ready = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
